// File: rtl/lcd_pkg.sv
// lcd_pkg: shared FSM states, HD44780 command constants and the power-up init ROM
package lcd_pkg;
  typedef enum logic [2:0] {S_PWRUP, S_INIT, S_IDLE, S_SNAP, S_ADDR, S_CHAR, S_DONE} lcd_state_t;
  typedef enum logic [2:0] {X_IDLE, X_SETUP, X_EHI, X_HOLD, X_WAIT} xfer_state_t;
  typedef enum logic [1:0] {W_CMD, W_CMD3, W_CLR, W_CLR3} wait_sel_t;
  typedef struct packed {
    logic [7:0] code;
    logic       is_nibble;
    wait_sel_t  wait_sel;
  } init_step_t;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_ENTRY = 8'h06;
  localparam logic [7:0] CMD_DISP_OFF = 8'h08;
  localparam logic [7:0] CMD_DISP_ON = 8'h0C;
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] FUNC_SET = 8'h20;
  localparam logic [7:0] FS_DL = 8'h10;
  localparam logic [7:0] FS_N = 8'h08;
  localparam logic [7:0] WAKE = 8'h30;
  localparam logic [6:0] DDRAM_BASE [4] = '{7'h00, 7'h40, 7'h14, 7'h54};
  // 8-bit panels skip the 0x2 "switch to 4-bit" nibble, so their step 3 maps onto ROM entry 4
  function automatic init_step_t init_rom(input int idx, input int bus_w, input int lines);
    int k;
    logic [7:0] fs;
    k = (bus_w == 8 && idx >= 3) ? idx + 1 : idx;
    fs = FUNC_SET | (bus_w == 8 ? FS_DL : 8'h00) | (lines > 1 ? FS_N : 8'h00);
    case (k)
      0: return '{WAKE, 1'b1, W_CLR3};
      1: return '{WAKE, 1'b1, W_CMD3};
      2: return '{WAKE, 1'b1, W_CMD};
      3: return '{FUNC_SET, 1'b1, W_CMD};
      4: return '{fs, 1'b0, W_CMD};
      5: return '{CMD_DISP_OFF, 1'b0, W_CMD};
      6: return '{CMD_CLEAR, 1'b0, W_CLR};
      7: return '{CMD_ENTRY, 1'b0, W_CMD};
      default: return '{CMD_DISP_ON, 1'b0, W_CMD};
    endcase
  endfunction
endpackage

// File: rtl/lcd_xfer_engine.sv
// lcd_xfer_engine: strobes one byte (or a lone high nibble) onto the LCD bus, then waits out its execution time
module lcd_xfer_engine
  import lcd_pkg::*;
#(
  parameter int BUS_W = 4,
  parameter int CMD_CYC = 2000,
  parameter int CLR_CYC = 82000,
  parameter int SETUP_CYC = 2,
  parameter int E_CYC = 12,
  parameter int CW = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_rs,
  input  logic [7:0]       i_byte,
  input  logic             i_nib,
  input  wait_sel_t        i_wsel,
  output logic             o_idle,
  output logic             o_done,
  output logic             o_e,
  output logic             o_rs,
  output logic [BUS_W-1:0] o_db
);
  xfer_state_t r_st, w_st_n;
  logic [CW-1:0] r_cnt, r_wait, w_lim, w_wait;
  logic [7:0] r_byte, w_sel;
  logic r_rs, r_nib, r_lo, r_e, w_last, w_split;
  always_comb begin
    w_lim = r_st == X_SETUP ? CW'(SETUP_CYC) : r_st == X_EHI ? CW'(E_CYC) : r_st == X_WAIT ? r_wait : CW'(1);
    w_last = r_cnt == w_lim - 1'b1;
    w_split = BUS_W == 4 && !r_nib && !r_lo;
    w_wait = i_wsel == W_CLR3 ? CW'(3 * CLR_CYC) : i_wsel == W_CLR ? CW'(CLR_CYC) :
             i_wsel == W_CMD3 ? CW'(3 * CMD_CYC) : CW'(CMD_CYC);
    w_sel = BUS_W == 8 ? r_byte : {4'h0, r_lo ? r_byte[3:0] : r_byte[7:4]};
    w_st_n = r_st;
    case (r_st)
      X_IDLE: w_st_n = i_start ? X_SETUP : X_IDLE;
      X_SETUP: w_st_n = w_last ? X_EHI : X_SETUP;
      X_EHI: w_st_n = w_last ? X_HOLD : X_EHI;
      X_HOLD: w_st_n = w_split ? X_SETUP : X_WAIT;
      X_WAIT: w_st_n = w_last ? X_IDLE : X_WAIT;
      default: w_st_n = X_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_st <= X_IDLE;
      r_cnt <= '0;
      r_wait <= '0;
      r_byte <= '0;
      r_rs <= 1'b0;
      r_nib <= 1'b0;
      r_lo <= 1'b0;
      r_e <= 1'b0;
    end else begin
      r_st <= w_st_n;
      r_cnt <= w_st_n == r_st ? r_cnt + 1'b1 : '0;
      r_e <= w_st_n == X_EHI;
      if (r_st == X_IDLE && i_start) begin
        r_rs <= i_rs;
        r_byte <= i_byte;
        r_nib <= i_nib;
        r_lo <= 1'b0;
        r_wait <= w_wait;
      end else if (r_st == X_HOLD && w_split) r_lo <= 1'b1;
    end
  end
  assign o_idle = r_st == X_IDLE;
  assign o_done = r_st == X_WAIT && w_last;
  assign o_e = r_e;
  assign o_rs = r_rs;
  assign o_db = w_sel[BUS_W-1:0];
endmodule

// File: rtl/lcd_multiline_ctrl.sv
// lcd_multiline_ctrl: HD44780 controller; runs power-up init, then copies a snapshot of
// an N-line text buffer into DDRAM on request, queueing one refresh if asked while busy.
module lcd_multiline_ctrl
  import lcd_pkg::*;
#(
  parameter int NUM_LINES = 2,
  parameter int LINE_CHARS = 16,
  parameter int BUS_W = 4,
  parameter int PWRUP_CYC = 750000,
  parameter int CMD_CYC = 2000,
  parameter int CLR_CYC = 82000,
  parameter int SETUP_CYC = 2,
  parameter int E_CYC = 12
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_LINES*LINE_CHARS*8-1:0]  line_data,
  input  logic                               update,
  output logic                               ready,
  output logic                               busy,
  output logic                               lcd_e,
  output logic                               lcd_rs,
  output logic                               lcd_rw,
  output logic [BUS_W-1:0]                   lcd_db
);
  localparam int NCH = NUM_LINES * LINE_CHARS;
  localparam int TOT = NCH * 8;
  localparam int IW = $clog2(NCH);
  localparam int LW = NUM_LINES > 1 ? $clog2(NUM_LINES) : 1;
  localparam int CHW = $clog2(LINE_CHARS);
  localparam int NSTEP = BUS_W == 4 ? 9 : 8;
  localparam int MAXW = PWRUP_CYC > 3 * CLR_CYC ? PWRUP_CYC : 3 * CLR_CYC;
  localparam int CW = $clog2(MAXW + 1);
  if (BUS_W != 4 && BUS_W != 8) begin : g_bad_bus
    $error("lcd_multiline_ctrl: BUS_W must be 4 or 8");
  end
  if (NUM_LINES < 1 || NUM_LINES > 4) begin : g_bad_lines
    $error("lcd_multiline_ctrl: NUM_LINES must be 1..4");
  end
  lcd_state_t r_state, w_state_n;
  logic [CW-1:0] r_cnt;
  logic [3:0] r_step;
  logic [LW-1:0] r_line;
  logic [CHW-1:0] r_char;
  logic [IW-1:0] r_idx;
  logic [TOT-1:0] r_buf;
  logic r_pend;
  init_step_t w_step;
  wait_sel_t w_wsel;
  logic [7:0] w_byte;
  logic [7:0] w_chars [NCH];
  logic w_done, w_idle, w_start, w_rs, w_nib, w_kick, w_cap;
  logic w_last_step, w_last_char, w_last_line;
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign w_chars[g] = r_buf[TOT-1-g*8 -: 8];
  end
  always_comb begin
    w_step = init_rom(int'(r_step), BUS_W, NUM_LINES);
    w_last_step = r_step == 4'(NSTEP - 1);
    w_last_char = r_char == CHW'(LINE_CHARS - 1);
    w_last_line = r_line == LW'(NUM_LINES - 1);
    w_kick = r_pend | update;
    w_start = w_idle && (r_state == S_INIT || r_state == S_ADDR || r_state == S_CHAR);
    w_rs = r_state == S_CHAR;
    w_nib = r_state == S_INIT && w_step.is_nibble;
    w_wsel = r_state == S_INIT ? w_step.wait_sel : W_CMD;
    w_byte = r_state == S_INIT ? w_step.code :
             r_state == S_ADDR ? CMD_SET_DDRAM | {1'b0, DDRAM_BASE[r_line]} : w_chars[r_idx];
    w_state_n = r_state;
    case (r_state)
      S_PWRUP: w_state_n = r_cnt == CW'(PWRUP_CYC - 1) ? S_INIT : S_PWRUP;
      S_INIT: w_state_n = !(w_done && w_last_step) ? S_INIT : w_kick ? S_SNAP : S_IDLE;
      S_IDLE: w_state_n = update ? S_SNAP : S_IDLE;
      S_SNAP: w_state_n = S_ADDR;
      S_ADDR: w_state_n = w_done ? S_CHAR : S_ADDR;
      S_CHAR: w_state_n = !(w_done && w_last_char) ? S_CHAR : w_last_line ? S_DONE : S_ADDR;
      S_DONE: w_state_n = w_kick ? S_SNAP : S_IDLE;
      default: w_state_n = S_PWRUP;
    endcase
    w_cap = w_state_n == S_SNAP && r_state != S_SNAP;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_PWRUP;
      r_cnt <= '0;
      r_step <= '0;
      r_line <= '0;
      r_char <= '0;
      r_idx <= '0;
      r_buf <= '0;
      r_pend <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt <= r_state == S_PWRUP ? r_cnt + 1'b1 : '0;
      // requests seen while busy collapse into one queued refresh, consumed when it is launched
      r_pend <= w_cap ? 1'b0 : r_pend | (update && r_state != S_IDLE);
      if (w_cap) r_buf <= line_data;
      if (r_state == S_INIT && w_done) r_step <= r_step + 1'b1;
      if (r_state == S_SNAP) begin
        r_line <= '0;
        r_char <= '0;
        r_idx <= '0;
      end else if (r_state == S_CHAR && w_done) begin
        r_idx <= r_idx + 1'b1;
        r_char <= w_last_char ? '0 : r_char + 1'b1;
        if (w_last_char) r_line <= r_line + 1'b1;
      end
    end
  end
  lcd_xfer_engine #(
    .BUS_W(BUS_W), .CMD_CYC(CMD_CYC), .CLR_CYC(CLR_CYC),
    .SETUP_CYC(SETUP_CYC), .E_CYC(E_CYC), .CW(CW)
  ) u_xfer (
    .clk(clk), .rst(rst), .i_start(w_start), .i_rs(w_rs), .i_byte(w_byte),
    .i_nib(w_nib), .i_wsel(w_wsel), .o_idle(w_idle), .o_done(w_done),
    .o_e(lcd_e), .o_rs(lcd_rs), .o_db(lcd_db)
  );
  assign ready = r_state == S_IDLE;
  assign busy = r_state != S_IDLE;
  assign lcd_rw = 1'b0;
endmodule

// File: tb/tb_lcd_multiline_ctrl.sv
// tb_lcd_multiline_ctrl: three controller configurations (2x16/4-bit, 1x8/8-bit, 4x20/8-bit)
// checked strobe-by-strobe against expected bus streams queued by each scenario.
module tb_lcd_multiline_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic upd [3];
  logic rdy [3], bsy [3], e_v [3], rs_v [3], rw_v [3];
  logic [7:0] db_v [3];
  logic [3:0] db4;
  logic [7:0] db8, db20;
  logic [255:0] d4;
  logic [63:0] d8;
  logic [639:0] d20;
  logic [8:0] q [3][$];
  logic pe [3];
  int wid [3];
  int n_pass = 0, n_total = 0;
  always #5 clk = ~clk;
  assign db_v[0] = {4'h0, db4};
  assign db_v[1] = db8;
  assign db_v[2] = db20;
  lcd_multiline_ctrl #(.NUM_LINES(2), .LINE_CHARS(16), .BUS_W(4), .PWRUP_CYC(20), .CMD_CYC(4),
    .CLR_CYC(10), .SETUP_CYC(1), .E_CYC(2)) u4 (
    .clk(clk), .rst(rst), .line_data(d4), .update(upd[0]), .ready(rdy[0]), .busy(bsy[0]),
    .lcd_e(e_v[0]), .lcd_rs(rs_v[0]), .lcd_rw(rw_v[0]), .lcd_db(db4));
  lcd_multiline_ctrl #(.NUM_LINES(1), .LINE_CHARS(8), .BUS_W(8), .PWRUP_CYC(20), .CMD_CYC(4),
    .CLR_CYC(10), .SETUP_CYC(1), .E_CYC(2)) u8 (
    .clk(clk), .rst(rst), .line_data(d8), .update(upd[1]), .ready(rdy[1]), .busy(bsy[1]),
    .lcd_e(e_v[1]), .lcd_rs(rs_v[1]), .lcd_rw(rw_v[1]), .lcd_db(db8));
  lcd_multiline_ctrl #(.NUM_LINES(4), .LINE_CHARS(20), .BUS_W(8), .PWRUP_CYC(20), .CMD_CYC(4),
    .CLR_CYC(10), .SETUP_CYC(1), .E_CYC(2)) u20 (
    .clk(clk), .rst(rst), .line_data(d20), .update(upd[2]), .ready(rdy[2]), .busy(bsy[2]),
    .lcd_e(e_v[2]), .lcd_rs(rs_v[2]), .lcd_rw(rw_v[2]), .lcd_db(db20));

  // advance one cycle; every E rising edge pops the scoreboard, every falling edge checks the pulse width
  task automatic step();
    logic [8:0] want;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      if (!rst) begin
        pe[d] = 1'b0;
        wid[d] = 0;
      end else begin
        if (e_v[d] && !pe[d]) begin
          n_total++;
          if (q[d].size() == 0)
            $display("FAIL strobe_dut%0d: got unexpected rs=%b db=%h, expected no strobe", d, rs_v[d], db_v[d]);
          else begin
            want = q[d].pop_front();
            if (rw_v[d] !== 1'b0 || {rs_v[d], db_v[d]} !== want)
              $display("FAIL strobe_dut%0d: got rw=%b rs/db=%h, expected rw=0 rs/db=%h", d, rw_v[d], {rs_v[d], db_v[d]}, want);
            else n_pass++;
          end
        end
        if (!e_v[d] && pe[d]) begin
          n_total++;
          if (wid[d] != 2) $display("FAIL e_width_dut%0d: got %0d cycles, expected 2", d, wid[d]);
          else n_pass++;
        end
        wid[d] = e_v[d] ? wid[d] + 1 : 0;
        pe[d] = e_v[d];
      end
    end
  endtask

  task automatic push_byte(input int d, input logic rs, input logic [7:0] b);
    if (d == 0) begin
      q[0].push_back({rs, 4'h0, b[7:4]});
      q[0].push_back({rs, 4'h0, b[3:0]});
    end else q[d].push_back({rs, b});
  endtask

  task automatic push_refresh(input int d, input logic [639:0] data, input int nl, input int nc);
    logic [6:0] base [4] = '{7'h00, 7'h40, 7'h14, 7'h54};
    int tot = nl * nc * 8;
    for (int l = 0; l < nl; l++) begin
      push_byte(d, 1'b0, {1'b1, base[l]});
      for (int c = 0; c < nc; c++) push_byte(d, 1'b1, data[tot-1-(l*nc+c)*8 -: 8]);
    end
  endtask

  task automatic push_init();
    logic [7:0] s4 [14] = '{8'h3, 8'h3, 8'h3, 8'h2, 8'h2, 8'h8, 8'h0, 8'h8, 8'h0, 8'h1, 8'h0, 8'h6, 8'h0, 8'hC};
    logic [7:0] s8 [8] = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h08, 8'h01, 8'h06, 8'h0C};
    logic [7:0] s20 [8] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
    foreach (s4[i]) q[0].push_back({1'b0, s4[i]});
    foreach (s8[i]) q[1].push_back({1'b0, s8[i]});
    foreach (s20[i]) q[2].push_back({1'b0, s20[i]});
  endtask

  task automatic pulse(input int d);
    upd[d] = 1'b1;
    step();
    upd[d] = 1'b0;
  endtask

  task automatic test_init_run();
    int early = 0;
    push_init();
    for (int i = 0; i < 20; i++) begin
      step();
      if (e_v[0] || e_v[1] || e_v[2]) early++;
    end
    n_total++;
    if (early != 0) $display("FAIL pwrup_quiet: got %0d cycles with E high, expected 0", early);
    else n_pass++;
    for (int i = 0; i < 3000 && !(rdy[0] && rdy[1] && rdy[2]); i++) step();
    for (int d = 0; d < 3; d++) begin
      n_total++;
      if (rdy[d] !== 1'b1 || q[d].size() != 0)
        $display("FAIL init_done_dut%0d: got ready=%b left=%0d, expected ready=1 left=0", d, rdy[d], q[d].size());
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    for (int d = 0; d < 3; d++) begin
      n_total++;
      if ({rdy[d], bsy[d], e_v[d], rs_v[d], rw_v[d], db_v[d]} !== 13'b0_1_0_0_0_00000000)
        $display("FAIL reset_dut%0d: got rdy/bsy/e/rs/rw/db=%b, expected 0100000000000", d,
                 {rdy[d], bsy[d], e_v[d], rs_v[d], rw_v[d], db_v[d]});
      else n_pass++;
    end
    rst = 1'b1;
    test_init_run();
  endtask

  task automatic test_refresh_2x16();
    d4 = {"HELLO, WORLD 123", "line two: abcdef"};
    push_refresh(0, {384'h0, d4}, 2, 16);
    pulse(0);
    d4 = '1;
    step();
    n_total++;
    if (rdy[0] !== 1'b0 || bsy[0] !== 1'b1) $display("FAIL refresh_accept: got ready=%b busy=%b, expected 0/1", rdy[0], bsy[0]);
    else n_pass++;
    for (int i = 0; i < 3000 && !rdy[0]; i++) step();
    n_total++;
    if (rdy[0] !== 1'b1 || q[0].size() != 0)
      $display("FAIL refresh_2x16_done: got ready=%b left=%0d, expected ready=1 left=0", rdy[0], q[0].size());
    else n_pass++;
  endtask

  task automatic test_one_line_8bit();
    d8 = "ABCDEFGH";
    push_refresh(1, {576'h0, d8}, 1, 8);
    pulse(1);
    d8 = '0;
    for (int i = 0; i < 1000 && !rdy[1]; i++) step();
    n_total++;
    if (rdy[1] !== 1'b1 || q[1].size() != 0)
      $display("FAIL refresh_1x8_done: got ready=%b left=%0d, expected ready=1 left=0", rdy[1], q[1].size());
    else n_pass++;
  endtask

  task automatic test_4x20();
    for (int k = 0; k < 20; k++) d20[k*32 +: 32] = $urandom();
    push_refresh(2, d20, 4, 20);
    pulse(2);
    for (int i = 0; i < 5000 && !rdy[2]; i++) step();
    n_total++;
    if (rdy[2] !== 1'b1 || q[2].size() != 0)
      $display("FAIL refresh_4x20_done: got ready=%b left=%0d, expected ready=1 left=0", rdy[2], q[2].size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int hi = 0, lo = 0;
    for (int k = 0; k < 8; k++) d4[k*32 +: 32] = $urandom();
    push_refresh(0, {384'h0, d4}, 2, 16);
    pulse(0);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 40; i++) step();
      for (int k = 0; k < 8; k++) d4[k*32 +: 32] = $urandom();
      pulse(0);
    end
    push_refresh(0, {384'h0, d4}, 2, 16);
    for (int i = 0; i < 5000 && q[0].size() != 0; i++) begin
      step();
      if (rdy[0]) hi++;
    end
    n_total++;
    if (hi != 0 || q[0].size() != 0)
      $display("FAIL back_to_back: got ready-high=%0d left=%0d, expected 0/0", hi, q[0].size());
    else n_pass++;
    for (int i = 0; i < 200 && !rdy[0]; i++) step();
    for (int i = 0; i < 300; i++) begin
      step();
      if (!rdy[0]) lo++;
    end
    n_total++;
    if (lo != 0) $display("FAIL single_extra_refresh: got %0d not-ready cycles after done, expected 0", lo);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lo = 0;
    for (int k = 0; k < 8; k++) d4[k*32 +: 32] = $urandom();
    push_refresh(0, {384'h0, d4}, 2, 16);
    pulse(0);
    step();
    pulse(0);
    for (int i = 0; i < 3000 && !(e_v[0] && q[0].size() < 40); i++) step();
    n_total++;
    if (e_v[0] !== 1'b1) $display("FAIL mid_strobe_reached: got e=%b, expected 1", e_v[0]);
    else n_pass++;
    rst = 1'b0;
    step();
    n_total++;
    if ({rdy[0], bsy[0], e_v[0], rs_v[0], rw_v[0], db_v[0]} !== 13'b0_1_0_0_0_00000000)
      $display("FAIL mid_reset: got rdy/bsy/e/rs/rw/db=%b, expected 0100000000000",
               {rdy[0], bsy[0], e_v[0], rs_v[0], rw_v[0], db_v[0]});
    else n_pass++;
    for (int d = 0; d < 3; d++) q[d].delete();
    rst = 1'b1;
    test_init_run();
    for (int i = 0; i < 300; i++) begin
      step();
      if (!rdy[0]) lo++;
    end
    n_total++;
    if (lo != 0) $display("FAIL pending_cleared: got %0d not-ready cycles after re-init, expected 0", lo);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      upd[d] = 1'b0;
      pe[d] = 1'b0;
      wid[d] = 0;
    end
    d4 = '0;
    d8 = '0;
    d20 = '0;
    test_reset();
    test_refresh_2x16();
    test_one_line_8bit();
    test_4x20();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
